// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the sensor LUT I2C writer.
// Holds the FSM state set, quarter phases and the delay-entry tag.
package i2c_cfg_pkg;

   typedef enum logic [3:0] {
      ST_INIT_WAIT,
      ST_LOAD,
      ST_START,
      ST_BYTE,
      ST_ACK,
      ST_STOP,
      ST_GAP,
      ST_NEXT,
      ST_DELAY,
      ST_DONE
   } state_t;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   localparam logic [15:0] DELAY_TAG = 16'hFFFF;

   localparam int MIN_CNT_W = 1;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : MIN_CNT_W;
   endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit divider: one-cycle tick every DIV clocks while enabled.
// Clear (or a tick) returns the count to zero so each quarter is exact.
module i2c_quarter_tick
   import i2c_cfg_pkg::*;
#(
   parameter int DIV = 62
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int W = cnt_width(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] r_cnt;

   assign o_tick = i_en && (r_cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || i_clr || o_tick) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2c_lut_write_ctrl.sv
// Walks the sensor register LUT and writes each entry over I2C.
// I2C_LUT_DELAY_ENTRY_EN: reg_addr 16'hFFFF entries become ms waits.
module i2c_lut_write_ctrl
   import i2c_cfg_pkg::*;
#(
   parameter int         CLK_FREQ   = 25_000_000,
   parameter int         I2C_FREQ   = 100_000,
   parameter logic [7:0] SLAVE_ADDR = 8'h60,
   parameter int         INIT_DELAY = 1_000_000,
   parameter int         MAX_RETRY  = 3
) (
   input  logic        clk,
   input  logic        rst,
   output logic [7:0]  LUT_INDEX,
   input  logic [23:0] LUT_DATA,
   input  logic [7:0]  LUT_SIZE,
   output logic        i2c_sclk,
   output logic        sda_out,
   output logic        sda_oe,
   input  logic        sda_in,
   output logic        i2c_busy,
   output logic        i2c_config_done,
   output logic        i2c_config_error
);

   localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);
   localparam logic [31:0] INIT_LAST = 32'(INIT_DELAY - 1);
   localparam logic [7:0] RETRY_LAST = 8'(MAX_RETRY - 1);

   state_t      r_state;
   logic [1:0]  r_q;
   logic [31:0] r_buf;
   logic [2:0]  r_bit;
   logic [1:0]  r_byte;
   logic        r_nack;
   logic [7:0]  r_rcnt;
   logic [31:0] r_dly;
   logic [7:0]  r_idx;
   logic        r_scl;
   logic        r_sda;
   logic        r_oe;
   logic        r_busy;
   logic        r_done;
   logic        r_err;

   logic        w_tick;
   logic        w_run;
   logic        w_last_idx;

   assign w_run = (r_state == ST_START) || (r_state == ST_BYTE)
               || (r_state == ST_ACK) || (r_state == ST_STOP)
               || (r_state == ST_GAP);

   assign w_last_idx = (({1'b0, r_idx} + 9'd1) == {1'b0, LUT_SIZE});

`ifdef I2C_LUT_DELAY_ENTRY_EN
   localparam logic [31:0] MS_CYC = 32'(CLK_FREQ / 1000);
   logic [31:0] w_dly_last;
   assign w_dly_last = 32'(r_buf[7:0]) * MS_CYC - 32'd1;
`endif

   i2c_quarter_tick #(
      .DIV(DIV)
   ) u_qtick (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_run),
      .i_clr (~w_run),
      .o_tick(w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_INIT_WAIT;
         r_q     <= Q0;
         r_buf   <= '0;
         r_bit   <= '0;
         r_byte  <= '0;
         r_nack  <= 1'b0;
         r_rcnt  <= '0;
         r_dly   <= '0;
         r_idx   <= '0;
         r_scl   <= 1'b1;
         r_sda   <= 1'b1;
         r_oe    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         unique case (r_state)
            ST_INIT_WAIT: begin
               if (r_dly == INIT_LAST) begin
                  r_dly   <= '0;
                  r_state <= (LUT_SIZE == 8'd0) ? ST_DONE : ST_LOAD;
               end else begin
                  r_dly <= r_dly + 32'd1;
               end
            end
            ST_LOAD: begin
               r_buf  <= {SLAVE_ADDR & 8'hFE, LUT_DATA};
               r_nack <= 1'b0;
               r_bit  <= '0;
               r_byte <= '0;
               r_q    <= Q0;
`ifdef I2C_LUT_DELAY_ENTRY_EN
               if (LUT_DATA[23:8] == DELAY_TAG) begin
                  r_state <= (LUT_DATA[7:0] == 8'd0) ? ST_NEXT : ST_DELAY;
               end else begin
                  r_state <= ST_START;
               end
`else
               r_state <= ST_START;
`endif
            end
            ST_START: begin
               if (w_tick) begin
                  r_q <= r_q + 2'd1;
                  if (r_q == Q3) r_state <= ST_BYTE;
               end
            end
            ST_BYTE: begin
               if (w_tick) begin
                  r_q <= r_q + 2'd1;
                  if (r_q == Q3) begin
                     r_buf <= {r_buf[30:0], 1'b0};
                     r_bit <= r_bit + 3'd1;
                     if (r_bit == 3'd7) r_state <= ST_ACK;
                  end
               end
            end
            ST_ACK: begin
               if (w_tick) begin
                  r_q <= r_q + 2'd1;
                  if (r_q == Q2) r_nack <= sda_in;
                  if (r_q == Q3) begin
                     if (r_nack || (r_byte == 2'd3)) begin
                        r_state <= ST_STOP;
                     end else begin
                        r_byte  <= r_byte + 2'd1;
                        r_state <= ST_BYTE;
                     end
                  end
               end
            end
            ST_STOP: begin
               if (w_tick) begin
                  r_q <= r_q + 2'd1;
                  if (r_q == Q3) r_state <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (w_tick) begin
                  r_q <= r_q + 2'd1;
                  if (r_q == Q3) r_state <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               if (r_nack && (r_rcnt < RETRY_LAST)) begin
                  r_rcnt  <= r_rcnt + 8'd1;
                  r_state <= ST_LOAD;
               end else begin
                  r_rcnt <= '0;
                  if (r_nack) r_err <= 1'b1;
                  if (w_last_idx) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_idx   <= r_idx + 8'd1;
                     r_state <= ST_LOAD;
                  end
               end
            end
            ST_DELAY: begin
`ifdef I2C_LUT_DELAY_ENTRY_EN
               if (r_dly == w_dly_last) begin
                  r_dly   <= '0;
                  r_state <= ST_NEXT;
               end else begin
                  r_dly <= r_dly + 32'd1;
               end
`else
               r_state <= ST_NEXT;
`endif
            end
            ST_DONE: r_done <= 1'b1;
            default: r_state <= ST_INIT_WAIT;
         endcase

         // Pad drive follows the current quarter one clock later.
         r_busy <= (r_state == ST_LOAD) || (r_state == ST_START)
                || (r_state == ST_BYTE) || (r_state == ST_ACK)
                || (r_state == ST_STOP) || (r_state == ST_DELAY);
         unique case (r_state)
            ST_START: begin
               r_scl <= 1'b1;
               r_oe  <= 1'b1;
               r_sda <= ~r_q[1];
            end
            ST_BYTE: begin
               r_scl <= r_q[1];
               r_oe  <= 1'b1;
               r_sda <= r_buf[31];
            end
            ST_ACK: begin
               r_scl <= r_q[1];
               r_oe  <= 1'b0;
               r_sda <= 1'b1;
            end
            ST_STOP: begin
               r_scl <= r_q[1];
               r_oe  <= 1'b1;
               r_sda <= (r_q == Q3);
            end
            default: begin
               r_scl <= 1'b1;
               r_oe  <= 1'b0;
               r_sda <= 1'b1;
            end
         endcase
      end
   end

   assign LUT_INDEX        = r_idx;
   assign i2c_sclk         = r_scl;
   assign sda_out          = r_sda;
   assign sda_oe           = r_oe;
   assign i2c_busy         = r_busy;
   assign i2c_config_done  = r_done;
   assign i2c_config_error = r_err;

endmodule
